picosoc_bus_fabric: RTL
=======================

// Module: picosoc_bus_fabric
// PURPOSE
//  Parametrised native-bus (valid/ready/addr/wdata/wstrb/rdata) decoder between the picorv32 master and N slaves.
//  Decodes by base/mask table, registers slave select, steers write data and strobes, and muxes read data back.
//  Also terminates unmapped or hung accesses with a bus-error response, an IRQ pulse, and address capture.
//  Replaces the hand-written ready-OR / rdata casez in the SoC top.
// PARAMETERS
//  N_SLV     6                   number of slave ports (1..16)
//  SLV_BASE  {N_SLV{32'h0}}      packed N_SLV*32 base addresses; slot i = [32*i+:32]
//  SLV_MASK  {N_SLV{32'hFFFF_FFFF}}  packed N_SLV*32 masks; hit_i = (m_addr & MASK_i) == BASE_i
//  TIMEOUT   255                 max cycles in ACTIVE awaiting s_ready; 0 = no timeout
//  ERR_DATA  32'hDEAD_BEEF       rdata returned on error completion
// PORTS
//  clk       in   1        system clock
//  resetn    in   1        synchronous reset, active low
//  m_valid   in   1        master request
//  m_addr    in   32       master address
//  m_wdata   in   32       master write data
//  m_wstrb   in   4        master byte strobes; 0 = read
//  m_ready   out  1        master completion, one-cycle pulse
//  m_rdata   out  32       master read data, valid while m_ready=1
//  s_valid   out  N_SLV    per-slave request (one-hot or zero)
//  s_addr    out  32       shared slave address (= m_addr)
//  s_wdata   out  32       shared slave write data (= m_wdata)
//  s_wstrb   out  4        m_wstrb in ACTIVE, else 0
//  s_ready   in   N_SLV    per-slave completion
//  s_rdata   in   N_SLV*32 per-slave read data; slot i = [32*i+:32]
//  err_clr   in   1        clears err_cnt
//  err_irq   out  1        one-cycle pulse on each error completion
//  err_addr  out  32       address of the most recent error access
//  err_cnt   out  8        saturating error count
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): state=IDLE, sel=0, tcnt=0, err_addr=0, err_cnt=0; all outputs 0.
//  FSM IDLE -> ACTIVE -> HOLD -> IDLE.
//   IDLE: m_valid=1 -> latch sel = lowest hit index (overlaps resolve to lowest i); no hit -> sel=NONE; go ACTIVE; tcnt=0.
//   ACTIVE, hit: s_valid[sel]=1; tcnt++ per cycle.
//    s_ready[sel]=1 -> m_ready=1 (combinational same cycle), m_rdata=s_rdata[sel]; go HOLD.
//    Else tcnt==TIMEOUT (TIMEOUT!=0) -> error completion; go HOLD.
//   ACTIVE, sel=NONE: error completion on first ACTIVE cycle; s_valid stays 0.
//   Error completion: m_ready=1, m_rdata=ERR_DATA, err_irq=1, err_addr<=m_addr, err_cnt<=sat(err_cnt+1).
//   HOLD: s_valid=0, m_ready=0 for exactly one cycle, so a still-high m_valid cannot retrigger a slave; then IDLE.
//  Latency: slave sees s_valid 1 cycle after m_valid.
//   Zero-wait slave (s_ready same cycle as s_valid) -> m_ready 1 cycle after m_valid.
//   Unmapped access -> m_ready 1 cycle after m_valid.
//   Timeout -> m_ready TIMEOUT+1 cycles after m_valid.
//  Back-to-back: minimum 3-cycle request period (IDLE, ACTIVE, HOLD).
//  Boundaries:
//   s_ready and timeout in same cycle -> normal completion, no error.
//   s_ready from a non-selected slave -> ignored.
//   m_valid drops in ACTIVE -> abort to IDLE; no m_ready, no error.
//   err_clr and error completion in same cycle -> err_cnt=1.
//   err_cnt holds at 255.
//   resetn low mid-ACTIVE -> next cycle IDLE; s_valid=0; err_* = 0.
//  Widths: tcnt is $clog2(TIMEOUT+1) bits, min 1; increment wraps never (bounded by compare).
//  m_rdata=0 whenever m_ready=0.
// STRUCTURE
//  picosoc_bus_pkg (`include header): FSM encodings S_IDLE/S_ACTIVE/S_HOLD, SEL_NONE, ERR_DATA default.
//  One sub-module: picosoc_bus_decode -- combinational base/mask priority encoder -> {hit, idx}.
//  Fabric holds FSM, timeout counter, error registers, rdata mux.
// TESTING
//  1. N_SLV=3; read to slave 1 with s_ready 0 wait, rdata=32'h1234_5678 -> m_ready at cycle +1, m_rdata=32'h1234_5678, s_valid=3'b010 for 1 cycle.
//  2. Write 32'hA5A5_0000, wstrb=4'b0011 to slave 2; s_ready after 3 waits -> s_wstrb=4'b0011 only in ACTIVE; m_ready at cycle +4; err_irq=0.
//  3. Access 32'h0F00_0000 (no hit) -> m_ready at +1, m_rdata=32'hDEAD_BEEF, err_irq pulse, err_addr=32'h0F00_0000, err_cnt=1, s_valid=0 throughout.
//  4. TIMEOUT=8, slave never ready -> m_ready at +9, err_cnt increments; repeat with s_ready at tcnt==8 -> normal data, no error.
//  5. m_valid held high after completion -> HOLD cycle has s_valid=0; slave sees exactly one new request per transaction.
//  6. Assert resetn=0 mid-ACTIVE, and err_clr coincident with an error -> all outputs 0 after reset; err_cnt=1 after clr/error collision.

Source files
------------

// File: rtl/picosoc_bus_pkg.sv
// Shared encodings for the picorv32 native-bus fabric: FSM states, select sentinel, default error data.
package picosoc_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    localparam int SEL_W = 5;
    // Sits above the 16-slave ceiling, so it can never alias a real slot.
    localparam logic [SEL_W-1:0] SEL_NONE = 5'h1F;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/picosoc_bus_decode.sv
// Combinational base/mask address decoder; overlapping windows resolve to the lowest slot index.
module picosoc_bus_decode
    import picosoc_bus_pkg::*;
#(
    parameter int                  N_SLV    = 6,
    parameter logic [N_SLV*32-1:0] SLV_BASE = {N_SLV{32'h0}},
    parameter logic [N_SLV*32-1:0] SLV_MASK = {N_SLV{32'hFFFF_FFFF}}
) (
    input  logic [31:0]      addr_i,
    output logic             hit_o,
    output logic [SEL_W-1:0] idx_o
);

    always_comb begin
        hit_o = 1'b0;
        idx_o = SEL_NONE;
        // Scan downwards so the lowest matching slot is the final writer.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit_o = 1'b1;
                idx_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/picosoc_bus_fabric.sv
// Native-bus fabric: registered slave select, read-data mux, timeout and bus-error termination.
module picosoc_bus_fabric
    import picosoc_bus_pkg::*;
#(
    parameter int                  N_SLV    = 6,
    parameter logic [N_SLV*32-1:0] SLV_BASE = {N_SLV{32'h0}},
    parameter logic [N_SLV*32-1:0] SLV_MASK = {N_SLV{32'hFFFF_FFFF}},
    parameter int                  TIMEOUT  = 255,
    parameter logic [31:0]         ERR_DATA = ERR_DATA_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                m_valid,
    input  logic [31:0]         m_addr,
    input  logic [31:0]         m_wdata,
    input  logic [3:0]          m_wstrb,
    output logic                m_ready,
    output logic [31:0]         m_rdata,
    output logic [N_SLV-1:0]    s_valid,
    output logic [31:0]         s_addr,
    output logic [31:0]         s_wdata,
    output logic [3:0]          s_wstrb,
    input  logic [N_SLV-1:0]    s_ready,
    input  logic [N_SLV*32-1:0] s_rdata,
    input  logic                err_clr,
    output logic                err_irq,
    output logic [31:0]         err_addr,
    output logic [7:0]          err_cnt
);

    localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic [31:0]        err_addr_q, err_addr_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_idx;
    logic [N_SLV-1:0]   sel_vec;
    logic               sel_ready;
    logic [31:0]        sel_rdata;
    logic               err_done;

    picosoc_bus_decode #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr_i (m_addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    always_comb begin
        sel_vec   = '0;
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_vec[i] = 1'b1;
                sel_ready  = s_ready[i];
                sel_rdata  = s_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        sel_d      = sel_q;
        tcnt_d     = tcnt_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_clr ? 8'd0 : err_cnt_q;
        m_ready    = 1'b0;
        m_rdata    = '0;
        s_valid    = '0;
        s_wstrb    = '0;
        err_irq    = 1'b0;
        err_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (m_valid) begin
                    state_d = S_ACTIVE;
                    sel_d   = dec_hit ? dec_idx : SEL_NONE;
                    tcnt_d  = '0;
                end
            end
            S_ACTIVE: begin
                s_wstrb = m_wstrb;
                if (!m_valid) begin
                    state_d = S_IDLE;
                end else if (sel_q != SEL_NONE) begin
                    s_valid = sel_vec;
                    if (sel_ready) begin
                        m_ready = 1'b1;
                        m_rdata = sel_rdata;
                        state_d = S_HOLD;
                    end else if (TIMEOUT != 0 && tcnt_q == TCNT_W'(TIMEOUT)) begin
                        err_done = 1'b1;
                    end else if (TIMEOUT != 0) begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end else begin
                    err_done = 1'b1;
                end

                if (err_done) begin
                    m_ready    = 1'b1;
                    m_rdata    = ERR_DATA;
                    err_irq    = 1'b1;
                    err_addr_d = m_addr;
                    // A clear colliding with an error still records that error.
                    err_cnt_d  = err_clr ? 8'd1 :
                                 (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            tcnt_q     <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            tcnt_q     <= tcnt_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign s_addr   = m_addr;
    assign s_wdata  = m_wdata;
    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;

endmodule
